// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage MIPS pipeline.
// Latency: all control outputs are combinational (Mealy on state + inputs); stall_count lags by one cycle.
// Backpressure: a memory wait freezes every pipeline register; load-use holds PC and IF/ID only.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset (outputs forced while low)
//   id_rs, id_rt, id_uses_rt         source operands of the ID instruction
//   ex_mem_read, ex_rt               load in EX and its destination register
//   branch_taken                     taken branch/jump resolved in EX
//   mem_req, mem_ready               MEM-stage data access handshake
//   *_we, *_flush, *_disable         pipeline register write enables and bubble controls
//   mem_err                          one-cycle pulse when an access is aborted on timeout
//   stall_count                      saturating count of cycles with pc_we=0
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5,
    parameter int REG_ADDR_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_we,
    output logic                  if_id_we,
    output logic                  if_id_flush,
    output logic                  id_ex_we,
    output logic                  id_ex_disable,
    output logic                  ex_mem_we,
    output logic                  mem_wb_disable,
    output logic                  mem_err,
    output logic [31:0]           stall_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } state_t;

    // The RUN cycle that starts the wait is already the first stall cycle,
    // so the abort fires when wait_cnt reaches MEM_TIMEOUT-1.
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             mem_stall;
    logic             load_use;

    assign load_use = ex_mem_read && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        mem_stall = 1'b0;
        case (state)
            RUN:      mem_stall = mem_req && !mem_ready;
            MEM_WAIT: mem_stall = !mem_ready;
            default:  mem_stall = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == LAST_WAIT) begin
                    state_nxt    = MEM_ERR;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // Output logic, highest-priority event last-wins is avoided: explicit if/else chain.
    always_comb begin
        pc_we          = 1'b1;
        if_id_we       = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_we       = 1'b1;
        id_ex_disable  = 1'b0;
        ex_mem_we      = 1'b1;
        mem_wb_disable = 1'b0;
        mem_err        = 1'b0;
        if (!rst_n) begin
            pc_we          = 1'b0;
            if_id_we       = 1'b0;
            if_id_flush    = 1'b1;
            id_ex_we       = 1'b0;
            id_ex_disable  = 1'b1;
            ex_mem_we      = 1'b0;
            mem_wb_disable = 1'b1;
        end else if (mem_stall) begin
            // Freeze everything; bubble MEM/WB so the stalled access is not written back twice.
            pc_we          = 1'b0;
            if_id_we       = 1'b0;
            id_ex_we       = 1'b0;
            ex_mem_we      = 1'b0;
            mem_wb_disable = 1'b1;
        end else begin
            if (state == MEM_ERR) begin
                mem_err        = 1'b1;
                mem_wb_disable = 1'b1;
            end
            if (branch_taken) begin
                if_id_flush   = 1'b1;
                id_ex_disable = 1'b1;
            end else if (load_use) begin
                pc_we         = 1'b0;
                if_id_we      = 1'b0;
                id_ex_disable = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (!pc_we && (stall_count != '1)) begin
            stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: fixed vector table, hand-written multi-cycle
// sequences, then randomized traffic, all checked against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_mem_read, branch_taken, mem_req, mem_ready;
    logic        pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_disable;
    logic        ex_mem_we, mem_wb_disable, mem_err;
    logic [31:0] stall_count;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(5), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_we(id_ex_we), .id_ex_disable(id_ex_disable), .ex_mem_we(ex_mem_we),
        .mem_wb_disable(mem_wb_disable), .mem_err(mem_err), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Output bundle order: pc_we if_id_we if_id_flush id_ex_we id_ex_disable ex_mem_we mem_wb_disable mem_err
    localparam logic [7:0] O_DEF   = 8'b11010100;
    localparam logic [7:0] O_LU    = 8'b00011100;
    localparam logic [7:0] O_BR    = 8'b11111100;
    localparam logic [7:0] O_MEM   = 8'b00000010;
    localparam logic [7:0] O_ERR   = 8'b11010111;
    localparam logic [7:0] O_RESET = 8'b00101010;

    logic [7:0] dut_out;
    assign dut_out = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_disable,
                      ex_mem_we, mem_wb_disable, mem_err};

    int checks = 0;
    int failures = 0;
    logic [7:0]  last_out;
    logic [31:0] last_cnt;

    // Behavioural model: tracks how many consecutive cycles the current access has stalled.
    bit              m_in_wait;
    int              m_waited;
    bit              m_err_now;
    longint unsigned m_cnt;

    function automatic void model_reset();
        m_in_wait = 0; m_waited = 0; m_err_now = 0; m_cnt = 0;
    endfunction

    function automatic bit model_mem_stall();
        if (m_in_wait) return !mem_ready;
        if (m_err_now) return 0;
        return mem_req && !mem_ready;
    endfunction

    function automatic logic [7:0] model_out();
        logic [7:0] o;
        bit lu;
        if (!rst_n) return O_RESET;
        if (model_mem_stall()) return O_MEM;
        o = O_DEF;
        if (m_err_now) begin o[1] = 1'b1; o[0] = 1'b1; end
        lu = ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
        if (branch_taken) begin o[5] = 1'b1; o[3] = 1'b1; end
        else if (lu) begin o[7] = 1'b0; o[6] = 1'b0; o[3] = 1'b1; end
        return o;
    endfunction

    function automatic void model_update();
        logic [7:0] o;
        o = model_out();
        if (!o[7] && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (model_mem_stall()) begin
            m_waited = m_waited + 1;
            if (m_waited == MEM_TIMEOUT) begin
                m_in_wait = 0; m_waited = 0; m_err_now = 1;
            end else begin
                m_in_wait = 1; m_err_now = 0;
            end
        end else begin
            m_in_wait = 0; m_waited = 0; m_err_now = 0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock cycle: compare at the falling edge, advance model at the rising edge.
    task automatic cycle(input string name);
        @(negedge clk);
        if (!rst_n) model_reset();
        check({name, ".out"}, {24'd0, dut_out}, {24'd0, model_out()});
        check({name, ".cnt"}, stall_count, m_cnt[31:0]);
        last_out = dut_out;
        last_cnt = stall_count;
        @(posedge clk);
        if (rst_n) model_update();
        #1;
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_mem_read = 0; ex_rt = 0;
        branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    typedef struct {
        string      name;
        logic [4:0] rs, rt, ert;
        logic       uses_rt, ld, br, mreq, mrdy;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c0;
        vecs[0] = '{"idle",      0, 0, 0, 0, 0, 0, 0, 0, O_DEF};
        vecs[1] = '{"lu_rs",     5, 0, 5, 0, 1, 0, 0, 0, O_LU};
        vecs[2] = '{"lu_clear",  5, 0, 5, 0, 0, 0, 0, 0, O_DEF};
        vecs[3] = '{"lu_r0",     0, 0, 0, 0, 1, 0, 0, 0, O_DEF};
        vecs[4] = '{"lu_rt",     3, 7, 7, 1, 1, 0, 0, 0, O_LU};
        vecs[5] = '{"rt_unused", 3, 7, 7, 0, 1, 0, 0, 0, O_DEF};
        vecs[6] = '{"br_lu",     5, 0, 5, 0, 1, 1, 0, 0, O_BR};
        vecs[7] = '{"mem_hit",   1, 2, 9, 1, 0, 0, 1, 1, O_DEF};
        vecs[8] = '{"br_only",   1, 2, 9, 1, 0, 1, 0, 1, O_BR};
        vecs[9] = '{"no_match",  4, 6, 8, 1, 1, 0, 0, 0, O_DEF};

        idle();
        rst_n = 1'b0;
        model_reset();
        cycle("reset");
        check("reset.forced", {24'd0, last_out}, {24'd0, O_RESET});
        check("reset.cnt0", last_cnt, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Vector table, one cycle each from RUN.
        c0 = stall_count;
        for (int i = 0; i < 10; i++) begin
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; ex_rt = vecs[i].ert;
            id_uses_rt = vecs[i].uses_rt; ex_mem_read = vecs[i].ld;
            branch_taken = vecs[i].br; mem_req = vecs[i].mreq; mem_ready = vecs[i].mrdy;
            cycle(vecs[i].name);
            check({"tbl.", vecs[i].name}, {24'd0, last_out}, {24'd0, vecs[i].exp});
        end
        idle(); cycle("post_tbl");
        check("tbl.stalls", last_cnt - c0, 32'd2);

        // Three-cycle memory wait, release on the fourth.
        c0 = last_cnt;
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cycle("mw");
            check("mw.frozen", {24'd0, last_out}, {24'd0, O_MEM});
        end
        mem_ready = 1; cycle("mw_rel");
        check("mw.release", {24'd0, last_out}, {24'd0, O_DEF});
        idle(); cycle("mw_after");
        check("mw.stalls", last_cnt - c0, 32'd3);

        // Branch held through a two-cycle wait is deferred to the release cycle.
        mem_req = 1; mem_ready = 0; branch_taken = 1;
        for (int i = 0; i < 2; i++) begin
            cycle("bw");
            check("bw.no_flush", {24'd0, last_out}, {24'd0, O_MEM});
        end
        mem_ready = 1; cycle("bw_rel");
        check("bw.flush", {24'd0, last_out}, {24'd0, O_BR});
        idle(); cycle("bw_after");

        // Timeout: 16 stall cycles, one MEM_ERR cycle, then RUN.
        c0 = last_cnt;
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            cycle("to");
            check("to.frozen", {24'd0, last_out}, {24'd0, O_MEM});
        end
        cycle("to_err");
        check("to.err", {24'd0, last_out}, {24'd0, O_ERR});
        idle(); cycle("to_run");
        check("to.run", {24'd0, last_out}, {24'd0, O_DEF});
        check("to.stalls", last_cnt - c0, 32'd16);

        // Reset in the fifth cycle of a wait.
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) cycle("rw");
        rst_n = 0;
        cycle("rw_rst");
        check("rw.forced", {24'd0, last_out}, {24'd0, O_RESET});
        rst_n = 1; mem_req = 0; mem_ready = 0;
        cycle("rw_run");
        check("rw.run", {24'd0, last_out}, {24'd0, O_DEF});
        check("rw.cnt0", last_cnt, 32'd0);

        // Randomized traffic with periodic forced long waits and rare resets.
        for (int i = 0; i < 600; i++) begin
            rst_n        = ($urandom_range(0, 149) != 0);
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            ex_rt        = 5'($urandom_range(0, 3));
            id_uses_rt   = 1'($urandom_range(0, 1));
            ex_mem_read  = ($urandom_range(0, 2) == 0);
            branch_taken = ($urandom_range(0, 4) == 0);
            mem_req      = ($urandom_range(0, 2) == 0);
            mem_ready    = ((i % 100) >= 78) ? 1'b0 : ($urandom_range(0, 9) < 7);
            cycle("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage MIPS pipeline. It detects load-use hazards, taken-branch flushes and multi-cycle data-memory waits. It drives the write-enable and bubble-insert (disable) controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. A small FSM tracks outstanding data-memory accesses, with timeout recovery, and the block keeps a saturating stall-cycle counter for performance debug.

Parameters:
MEM_TIMEOUT, 16, max cycles a MEM-stage access may wait for mem_ready before it is aborted (legal range 2..2^CNT_W-1)
CNT_W, 5, width of wait counter
REG_ADDR_W, 5, register-address width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs  in  REG_ADDR_W  rs field of the instruction in ID
id_rt  in  REG_ADDR_W  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_mem_read  in  1  instruction in EX is a load
ex_rt  in  REG_ADDR_W  destination of the load in EX
branch_taken  in  1  branch/jump in EX resolved taken
mem_req  in  1  instruction in MEM accesses data memory
mem_ready  in  1  data memory completes the access this cycle
pc_we  out  1  PC write enable
if_id_we  out  1  IF/ID write enable
if_id_flush  out  1  load a NOP into IF/ID
id_ex_we  out  1  ID/EX write enable
id_ex_disable  out  1  insert a bubble into ID/EX (zero WB/M/EX controls)
ex_mem_we  out  1  EX/MEM write enable
mem_wb_disable  out  1  insert a bubble into MEM/WB
mem_err  out  1  one-cycle pulse: memory access aborted on timeout
stall_count  out  32  saturating count of cycles with pc_we=0

Behaviour:
- FSM states: RUN, MEM_WAIT, MEM_ERR. Control outputs are Mealy (state + current inputs). stall_count, state and wait_cnt are registered.
- Reset (rst_n=0, async): state=RUN, wait_cnt=0, stall_count=0. While rst_n=0, the outputs are forced: all *_we=0, if_id_flush=1, id_ex_disable=1, mem_wb_disable=1, mem_err=0.
- Default (no event): all *_we=1; if_id_flush, id_ex_disable, mem_wb_disable and mem_err are 0.
- Event priority, highest first: memory stall > MEM_ERR > branch flush > load-use.
- Memory stall applies in RUN when mem_req=1 and mem_ready=0, and in MEM_WAIT when mem_ready=0.
  - Outputs: pc_we, if_id_we, id_ex_we and ex_mem_we are 0; mem_wb_disable=1; flushes are 0. The whole pipeline freezes and no duplicate writeback occurs.
- RUN -> MEM_WAIT on a memory stall; wait_cnt<=1. mem_req=1 with mem_ready=1 in the same cycle causes zero stall.
- In MEM_WAIT, mem_req is ignored (the access is latched in EX/MEM).
  - mem_ready=1: outputs are default or per lower-priority events; state goes to RUN and wait_cnt<=0.
  - mem_ready=0 and wait_cnt==MEM_TIMEOUT-1: goes to MEM_ERR. That cycle is still a stall cycle.
  - Otherwise: wait_cnt<=wait_cnt+1.
- MEM_ERR lasts exactly one cycle, then returns to RUN.
  - Outputs: mem_err=1, mem_wb_disable=1, all *_we=1, so the faulting instruction is dropped and the pipeline advances.
  - mem_req and mem_ready are ignored in this cycle.
  - Branch-flush and load-use rules still apply in this cycle.
- Branch flush (branch_taken=1, no memory stall): if_id_flush=1, id_ex_disable=1, all *_we=1 for that cycle.
  - Because EX is frozen during a memory stall, branch_taken persists, so a branch flush is deferred, not lost.
- Load-use hazard: ex_mem_read=1, ex_rt!=0, and either ex_rt==id_rs or (id_uses_rt=1 and ex_rt==id_rt).
  - Outputs: pc_we=0, if_id_we=0, id_ex_disable=1; the other *_we are 1.
  - Suppressed by a branch flush (the ID instruction is squashed anyway).
  - At most one cycle per hazard, since the inserted bubble clears ex_mem_read.
- stall_count increments on every cycle with rst_n=1 and pc_we=0. It saturates at 0xFFFFFFFF (no wrap).

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 -> pc_we=0, if_id_we=0, id_ex_disable=1 for exactly 1 cycle; stall_count=1. Repeat with ex_rt=0 -> no stall.
- Branch: branch_taken=1 with a simultaneous load-use match -> if_id_flush=1, id_ex_disable=1, pc_we=1; stall_count unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> all *_we=0 and mem_wb_disable=1 for 3 cycles; release on the 4th cycle; state back to RUN; stall_count=3.
- Branch during memory wait: branch_taken held through a 2-cycle wait -> no flush during the wait; flush on the release cycle.
- Timeout: MEM_TIMEOUT=16, mem_ready held 0 -> 16 stall cycles, then 1 MEM_ERR cycle with mem_err=1, mem_wb_disable=1 and all *_we=1; then RUN.
- Reset mid-wait: rst_n low in cycle 5 of MEM_WAIT -> immediate forced outputs (all *_we=0, bubbles=1); state=RUN and stall_count=0 after release.
